uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter that serialises one parallel payload word per request into an asynchronous frame on `uart_txd`: one start bit, `PAYLOAD_BITS` data bits LSB first, and `STOP_BITS` stop bits. It is the transmit end of the project's UART link and pairs with the existing receiver on the same bit-rate and frame parameters. The request interface is a simple enable/busy handshake, and the serial output is fully registered.

## Interface
- `BIT_RATE`, 9600: line bit rate in bit/s.
- `CLK_HZ`, 50_000_000: `clk` frequency in Hz.
- `PAYLOAD_BITS`, 8: data bits per frame, ≥1.
- `STOP_BITS`, 1: stop bits per frame, ≥1.
- Derived: `CYCLES_PER_BIT = (1_000_000_000/BIT_RATE) / (1_000_000_000/CLK_HZ)`, using integer division at each step. This is the same formula the receiver uses. Default value is 5208.
- `clk` in 1: system clock; all logic on its rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `uart_tx_en` in 1: send request; accepted only when `uart_tx_busy`=0.
- `uart_tx_data` in `PAYLOAD_BITS`: payload; sampled only on the accepting edge.
- `uart_tx_busy` out 1: frame in progress; new requests are ignored.
- `uart_txd` out 1: serial line; idle-high; driven directly from a flop.

## Operation
- Reset (`resetn`=0 at an edge) → state IDLE, `uart_txd`=1, `uart_tx_busy`=0, counters 0, shift register 0. This applies from any state: a partial frame is abandoned and the line returns high on that edge.
- FSM states:
  - IDLE → START on `uart_tx_en && !uart_tx_busy`. On that edge, load `uart_tx_data` into the shift register, set `uart_txd`=0 and `uart_tx_busy`=1.
  - START → SEND after `CYCLES_PER_BIT` cycles. `uart_txd` takes shift-register bit 0.
  - SEND: each bit lasts `CYCLES_PER_BIT` cycles, then the shift register shifts right by one and the bit counter increments. After `PAYLOAD_BITS` bits → STOP with `uart_txd`=1.
  - STOP: lasts `STOP_BITS*CYCLES_PER_BIT` cycles, then → IDLE with `uart_tx_busy`=0.
- Cycle counter counts 0..`CYCLES_PER_BIT`-1 and wraps at each bit boundary. Width is `$clog2(CYCLES_PER_BIT)`, minimum 1.
- Bit counter counts payload bits in SEND and stop bits in STOP. Width is `$clog2(max(PAYLOAD_BITS,STOP_BITS)+1)`. It clears on every state change.
- `uart_tx_en` while busy: ignored entirely. There is no queue, and no effect on the frame in flight.
- Changes to `uart_tx_data` after the accepting edge do not affect the frame.
- No parity.
- A payload of all zeros is sent normally; the receiver reports it as a break.

## Timing
- Let E0 be the accepting edge. Bit k of the frame occupies edges E0+k·CPB up to E0+(k+1)·CPB, where k=0 is start, k=1..P is data, and k>P is stop.
- Frame length is exactly (1+`PAYLOAD_BITS`+`STOP_BITS`)·`CYCLES_PER_BIT` cycles. `uart_tx_busy` is high for exactly this many cycles.
- `uart_tx_busy` falls on the same edge where the last stop bit ends. The line stays 1.
- If `uart_tx_en` is held high, the next request is accepted on the following edge. This gives exactly one idle-high cycle between frames.
- Request-to-start-bit latency: 0 cycles after E0. `uart_txd` is low in the first cycle after the accepting edge.
- The line has no glitches: `uart_txd` changes only at bit boundaries.

## Structure
- Shared package `uart_pkg`:
  - FSM enum `state_t` with IDLE/START/DATA/STOP encodings.
  - A `cycles_per_bit(bit_rate, clk_hz)` function, so the receiver and transmitter derive identical bit timing.
- One natural sub-module, `uart_bit_timer`:
  - Behaviour: a parameterised `CYCLES_PER_BIT` counter with `run` input and `bit_done` pulse.
  - Reuse: the receiver can adopt the same block later.
- Otherwise flat: FSM, shift register, bit counter and output flop in `uart_tx`.

## Test plan
Bench parameters: `CLK_HZ`=1_000_000, `BIT_RATE`=100_000, giving `CYCLES_PER_BIT`=10, unless stated otherwise.

1. Reset: hold `resetn`=0 for 3 cycles with `uart_tx_en`=1 → `uart_txd`=1 and `uart_tx_busy`=0 throughout. No frame starts until after release.
2. Single frame: send 0x55 → `uart_txd` carries 0,1,0,1,0,1,0,1,0,1, each held exactly 10 cycles. `uart_tx_busy` is high for exactly 100 cycles.
3. Request while busy: start 0x55, then pulse `uart_tx_en` with data 0xFF at cycle 37 → the 0x55 frame is unchanged and no second frame follows.
4. Back-to-back: hold `uart_tx_en`=1 with 0xA3, switching to 0x3C after acceptance → two correct frames separated by exactly one idle-high cycle.
5. Alternate parameters: `STOP_BITS`=2, `PAYLOAD_BITS`=7, send 0x7F → frame is 100 cycles with a 20-cycle stop. Loopback into the receiver with matching parameters yields `uart_rx_data`=0x7F.
6. Reset mid-frame: assert `resetn`=0 at cycle 45 of a 0x0F frame → line is 1 and busy is 0 on that edge. After release, sending 0x00 produces a clean frame that the receiver flags as break.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings and bit-timing derivation common to
// the transmitter and receiver.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;

    // Two-step integer division keeps TX and RX rounding identical.
    function automatic int cycles_per_bit(input int bit_rate, input int clk_hz);
        return (32'sd1_000_000_000 / bit_rate) / (32'sd1_000_000_000 / clk_hz);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CYCLES_PER_BIT-1 while run is high and pulses
// bit_done in the last cycle of each bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    output logic bit_done
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    assign bit_done = run && (cnt_r == LAST);

    // Cycle counter; held at zero while idle so each frame starts aligned.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r <= {CW{1'b0}};
        end else if (!run || bit_done) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop
// bits, with an enable/busy request handshake and a flop-driven serial line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(BIT_RATE, CLK_HZ);
    localparam int MAX_BITS       = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int BW             = $clog2(MAX_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_t                  state_r;
    logic [PAYLOAD_BITS-1:0] shift_r;
    logic [PAYLOAD_BITS-1:0] shifted_s;
    logic [BW-1:0]           bit_cnt_r;
    logic                    txd_r;
    logic                    busy_r;
    logic                    run_s;
    logic                    bit_done_s;

    assign run_s        = (state_r != IDLE);
    assign shifted_s    = shift_r >> 1;
    assign uart_txd     = txd_r;
    assign uart_tx_busy = busy_r;

    uart_bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run_s),
        .bit_done(bit_done_s)
    );

    // Frame sequencer; the line level for each bit is set on the edge that opens it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= IDLE;
            shift_r   <= {PAYLOAD_BITS{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (uart_tx_en && !busy_r) begin
                        state_r   <= START;
                        shift_r   <= uart_tx_data;
                        bit_cnt_r <= {BW{1'b0}};
                        txd_r     <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        state_r   <= DATA;
                        bit_cnt_r <= {BW{1'b0}};
                        txd_r     <= shift_r[0];
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        if (bit_cnt_r == LAST_DATA) begin
                            state_r   <= STOP;
                            bit_cnt_r <= {BW{1'b0}};
                            txd_r     <= 1'b1;
                        end else begin
                            shift_r   <= shifted_s;
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                            txd_r     <= shifted_s[0];
                        end
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        if (bit_cnt_r == LAST_STOP) begin
                            state_r   <= IDLE;
                            bit_cnt_r <= {BW{1'b0}};
                            busy_r    <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= {BW{1'b0}};
                    txd_r     <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a payload table plus hand-written corner sequences,
// with a mid-bit sampling receiver model for the loopback checks.
module tb_uart_tx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en_a, en_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       busy_a, busy_b, txd_a, txd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) u_a (
        .clk(clk), .resetn(resetn), .uart_tx_en(en_a), .uart_tx_data(data_a),
        .uart_tx_busy(busy_a), .uart_txd(txd_a));

    uart_tx #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(7), .STOP_BITS(2)) u_b (
        .clk(clk), .resetn(resetn), .uart_tx_en(en_b), .uart_tx_data(data_b),
        .uart_tx_busy(busy_b), .uart_txd(txd_b));

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_rx;
        logic       exp_lsb;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic e, input logic [7:0] d);
        if (sel == 0) begin
            en_a   = e;
            data_a = d;
        end else begin
            en_b   = e;
            data_b = d[6:0];
        end
    endtask

    // Sends one frame, checks every cycle of the line and busy, returns the
    // payload recovered by mid-bit sampling. inj>=0 pulses a 0xFF request then.
    task automatic send_frame(input int sel, input logic [7:0] d, input int p, input int s,
                              input int inj, input bit hold, input logic [7:0] nxt,
                              input string name, output logic [7:0] rx,
                              output logic first_bit);
        int   n, k, bad_wave, bad_busy, first_bad;
        logic exp_t, got_t, got_b;
        logic [7:0] dv;
        dv = d;
        rx = 8'h00;
        first_bit = 1'b1;
        bad_wave = 0;
        bad_busy = 0;
        first_bad = -1;
        n = (1 + p + s) * CPB;
        drive(sel, 1'b1, d);
        step();
        drive(sel, hold, nxt);
        for (int c = 0; c < n; c++) begin
            got_t = (sel == 0) ? txd_a : txd_b;
            got_b = (sel == 0) ? busy_a : busy_b;
            k = c / CPB;
            exp_t = (k == 0) ? 1'b0 : ((k <= p) ? dv[k-1] : 1'b1);
            if (got_t !== exp_t) begin
                bad_wave++;
                if (first_bad < 0) first_bad = c;
            end
            if (got_b !== 1'b1) bad_busy++;
            if (k >= 1 && k <= p && c == k * CPB + CPB / 2) rx[k-1] = got_t;
            if (c == CPB + CPB / 2) first_bit = got_t;
            if (c == inj) drive(sel, 1'b1, 8'hFF);
            if (inj >= 0 && c == inj + 1) drive(sel, 1'b0, 8'hFF);
            step();
        end
        if (bad_wave != 0)
            $display("FAIL %s wave: %0d wrong cycles, first at cycle %0d", name, bad_wave, first_bad);
        checks++;
        if (bad_wave != 0) errors++;
        check({name, " busy_high_cycles"}, n - bad_busy, n);
        check({name, " end_busy"}, (sel == 0) ? busy_a : busy_b, 1'b0);
        check({name, " end_txd"}, (sel == 0) ? txd_a : txd_b, 1'b1);
    endtask

    initial begin
        vec_t       vecs[5];
        logic [7:0] rx;
        logic       fb;
        int         bad;

        vecs[0] = '{data: 8'h55, exp_rx: 8'h55, exp_lsb: 1'b1};
        vecs[1] = '{data: 8'h00, exp_rx: 8'h00, exp_lsb: 1'b0};
        vecs[2] = '{data: 8'hFF, exp_rx: 8'hFF, exp_lsb: 1'b1};
        vecs[3] = '{data: 8'h81, exp_rx: 8'h81, exp_lsb: 1'b1};
        vecs[4] = '{data: 8'hC6, exp_rx: 8'hC6, exp_lsb: 1'b0};

        // Reset held with a pending request: line idle, nothing starts.
        resetn = 1'b0;
        en_a = 1'b1; data_a = 8'h55;
        en_b = 1'b0; data_b = 7'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_txd", txd_a, 1'b1);
            check("reset_busy", busy_a, 1'b0);
        end
        en_a = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("post_reset_busy", busy_a, 1'b0);
            check("post_reset_txd", txd_a, 1'b1);
        end

        foreach (vecs[i]) begin
            send_frame(0, vecs[i].data, 8, 1, -1, 1'b0, 8'h00, "table", rx, fb);
            check("table_rx", rx, vecs[i].exp_rx);
            check("table_lsb", fb, vecs[i].exp_lsb);
            step();
        end

        // Request while busy is ignored and leaves no queued frame.
        send_frame(0, 8'h55, 8, 1, 37, 1'b0, 8'h00, "busy_req", rx, fb);
        check("busy_req_rx", rx, 8'h55);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy_a !== 1'b0 || txd_a !== 1'b1) bad++;
            step();
        end
        check("busy_req_no_second", bad, 0);

        // Back-to-back with enable held; data changes after acceptance.
        send_frame(0, 8'hA3, 8, 1, -1, 1'b1, 8'h3C, "b2b_first", rx, fb);
        check("b2b_first_rx", rx, 8'hA3);
        send_frame(0, 8'h3C, 8, 1, -1, 1'b0, 8'h00, "b2b_second", rx, fb);
        check("b2b_second_rx", rx, 8'h3C);

        // 7 data bits, 2 stop bits.
        send_frame(1, 8'h7F, 7, 2, -1, 1'b0, 8'h00, "alt", rx, fb);
        check("alt_rx", rx, 8'h7F);

        // Reset in the middle of a frame, then an all-zero (break) frame.
        drive(0, 1'b1, 8'h0F);
        step();
        drive(0, 1'b0, 8'h0F);
        for (int i = 0; i < 44; i++) step();
        check("midreset_busy_before", busy_a, 1'b1);
        resetn = 1'b0;
        step();
        check("midreset_txd", txd_a, 1'b1);
        check("midreset_busy", busy_a, 1'b0);
        resetn = 1'b1;
        step();
        check("midreset_idle", busy_a, 1'b0);
        send_frame(0, 8'h00, 8, 1, -1, 1'b0, 8'h00, "break", rx, fb);
        check("break_rx", rx, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
